basic_cpu_core: RTL and testbench

- Accumulator CPU for the basic SoC. Shares one address bus, one bidirectional data bus and one write strobe with a RAM and a boot ROM.
- After reset it copies the program image from ROM into RAM (boot phase). It then fetches and executes 8-bit instructions from RAM, using an internal ALU.

---
 rtl/cpu_pkg.sv | 47 ++++
 rtl/basic_cpu_core_if.sv | 20 ++
 rtl/cpu_alu.sv | 57 +++++
 rtl/basic_cpu_core.sv | 167 ++++++++++++++++
 tb/tb_basic_cpu_core.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared types for the basic accumulator CPU: default sizes, opcode and
// FSM state encodings, and small opcode classification helpers.
package cpu_pkg;

    localparam int DEF_WORD_SIZE = 8;
    localparam int DEF_ADDR_SIZE = 8;
    localparam int DEF_PROG_LEN  = 16;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDA = 4'h1,
        OP_STA = 4'h2,
        OP_ADD = 4'h3,
        OP_SUB = 4'h4,
        OP_AND = 4'h5,
        OP_OR  = 4'h6,
        OP_XOR = 4'h7,
        OP_LDI = 4'h8,
        OP_JMP = 4'h9,
        OP_JZ  = 4'hA,
        OP_JC  = 4'hB,
        OP_NOT = 4'hC,
        OP_SHL = 4'hD,
        OP_SHR = 4'hE,
        OP_HLT = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_BOOT  = 3'd1,
        S_FETCH = 3'd2,
        S_EXEC  = 3'd3,
        S_HALT  = 3'd4
    } state_e;

    // Instructions whose second operand is the RAM word at the operand address.
    function automatic logic reads_mem(opcode_e op);
        return op inside {OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR};
    endfunction

    // Instructions that load a new accumulator value (and hence update Z).
    function automatic logic writes_acc(opcode_e op);
        return op inside {OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
                          OP_LDI, OP_NOT, OP_SHL, OP_SHR};
    endfunction

endpackage

// File: rtl/basic_cpu_core_if.sv
// Architectural status bundle of the CPU (ACC, PC, flags, halted).
// master: driven by the core; slave: observers such as debug or a bench.
interface cpu_status_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic [DW-1:0] acc;
    logic [AW-1:0] pc;
    logic          z;
    logic          c;
    logic          halted;

    modport master (
        output acc, pc, z, c, halted
    );

    modport slave (
        input acc, pc, z, c, halted
    );
endinterface

// File: rtl/cpu_alu.sv
// Combinational ALU of the accumulator CPU.
// Ports: op_i opcode, a_i ACC, b_i operand, c_i carry in; result_o, c_o, z_o.
module cpu_alu
    import cpu_pkg::*;
#(
    parameter int W = DEF_WORD_SIZE
) (
    input  opcode_e      op_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         c_i,
    output logic [W-1:0] result_o,
    output logic         c_o,
    output logic         z_o
);

    logic [W:0] wide;

    always_comb begin
        result_o = a_i;
        c_o      = c_i;
        wide     = '0;
        unique case (op_i)
            OP_LDA, OP_LDI: result_o = b_i;
            OP_ADD: begin
                wide     = {1'b0, a_i} + {1'b0, b_i};
                result_o = wide[W-1:0];
                c_o      = wide[W];
            end
            OP_SUB: begin
                // Top bit of the widened difference is the borrow.
                wide     = {1'b0, a_i} - {1'b0, b_i};
                result_o = wide[W-1:0];
                c_o      = wide[W];
            end
            OP_AND: result_o = a_i & b_i;
            OP_OR:  result_o = a_i | b_i;
            OP_XOR: result_o = a_i ^ b_i;
            OP_NOT: result_o = ~a_i;
            OP_SHL: begin
                result_o = {a_i[W-2:0], 1'b0};
                c_o      = a_i[W-1];
            end
            OP_SHR: begin
                result_o = {1'b0, a_i[W-1:1]};
                c_o      = a_i[0];
            end
            default: begin
                result_o = a_i;
                c_o      = c_i;
            end
        endcase
    end

    assign z_o = (result_o == '0);

endmodule

// File: rtl/basic_cpu_core.sv
// Accumulator CPU: boots the program from ROM into RAM, then runs
// FETCH/EXEC on RAM. Ports: clk, rst (async active-low), addr_bus,
// data_bus (inout, driven only on STA), wr_en, boot, status (master).
module basic_cpu_core
    import cpu_pkg::*;
#(
    parameter int WORD_SIZE = DEF_WORD_SIZE,
    parameter int ADDR_SIZE = DEF_ADDR_SIZE,
    parameter int PROG_LEN  = DEF_PROG_LEN
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic [ADDR_SIZE-1:0] addr_bus,
    inout  wire  [WORD_SIZE-1:0] data_bus,
    output logic                 wr_en,
    output logic                 boot,
    cpu_status_if.master         status
);

    state_e                state_q, state_d;
    logic [ADDR_SIZE-1:0]  pc_q, pc_d;
    logic [ADDR_SIZE-1:0]  cnt_q, cnt_d;
    logic [WORD_SIZE-1:0]  acc_q, acc_d;
    logic [WORD_SIZE-1:0]  ir_q, ir_d;
    logic                  z_q, z_d;
    logic                  c_q, c_d;

    opcode_e               op;
    logic [3:0]            operand;
    logic [ADDR_SIZE-1:0]  operand_addr;
    logic [WORD_SIZE-1:0]  alu_b;
    logic [WORD_SIZE-1:0]  alu_res;
    logic                  alu_c;
    logic                  alu_z;
    logic                  drive_en;
    logic                  boot_last;

    assign op           = opcode_e'(ir_q[7:4]);
    assign operand      = ir_q[3:0];
    assign operand_addr = ADDR_SIZE'(operand);
    assign boot_last    = (cnt_q == ADDR_SIZE'(PROG_LEN - 1));

    // LDI takes its value from the instruction, everything else from RAM.
    assign alu_b = (op == OP_LDI) ? WORD_SIZE'(operand) : data_bus;

    cpu_alu #(
        .W (WORD_SIZE)
    ) u_alu (
        .op_i     (op),
        .a_i      (acc_q),
        .b_i      (alu_b),
        .c_i      (c_q),
        .result_o (alu_res),
        .c_o      (alu_c),
        .z_o      (alu_z)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_INIT;
            pc_q    <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            ir_q    <= '0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            ir_q    <= ir_d;
            z_q     <= z_d;
            c_q     <= c_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_INIT:  state_d = S_BOOT;
            S_BOOT:  state_d = boot_last ? S_FETCH : S_BOOT;
            S_FETCH: state_d = S_EXEC;
            S_EXEC:  state_d = (op == OP_HLT) ? S_HALT : S_FETCH;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_INIT;
        endcase
    end

    always_comb begin
        addr_bus = '0;
        wr_en    = 1'b0;
        boot     = 1'b0;
        drive_en = 1'b0;
        unique case (state_q)
            S_INIT: boot = 1'b1;
            S_BOOT: begin
                addr_bus = cnt_q;
                wr_en    = 1'b1;
                boot     = 1'b1;
            end
            S_FETCH: addr_bus = pc_q;
            S_EXEC: begin
                addr_bus = pc_q;
                if (reads_mem(op)) begin
                    addr_bus = operand_addr;
                end
                if (op == OP_STA) begin
                    addr_bus = operand_addr;
                    wr_en    = 1'b1;
                    drive_en = 1'b1;
                end
            end
            S_HALT: addr_bus = pc_q;
            default: boot = 1'b1;
        endcase
    end

    assign data_bus = drive_en ? acc_q : {WORD_SIZE{1'bz}};

    always_comb begin
        pc_d  = pc_q;
        cnt_d = cnt_q;
        acc_d = acc_q;
        ir_d  = ir_q;
        z_d   = z_q;
        c_d   = c_q;
        unique case (state_q)
            S_INIT: cnt_d = '0;
            S_BOOT: begin
                cnt_d = cnt_q + 1'b1;
                if (boot_last) begin
                    pc_d = '0;
                end
            end
            S_FETCH: begin
                ir_d = data_bus;
                pc_d = pc_q + 1'b1;
            end
            S_EXEC: begin
                if (writes_acc(op)) begin
                    // ALU passes c_q through for ops that keep C.
                    acc_d = alu_res;
                    z_d   = alu_z;
                    c_d   = alu_c;
                end
                if (op == OP_JMP) begin
                    pc_d = operand_addr;
                end
                if (op == OP_JZ && z_q) begin
                    pc_d = operand_addr;
                end
                if (op == OP_JC && c_q) begin
                    pc_d = operand_addr;
                end
            end
            default: ;
        endcase
    end

    assign status.acc    = acc_q;
    assign status.pc     = pc_q;
    assign status.z      = z_q;
    assign status.c      = c_q;
    assign status.halted = (state_q == S_HALT);

endmodule

// File: tb/tb_basic_cpu_core.sv
// Directed bench for basic_cpu_core with behavioural ROM and RAM on the
// shared bus; checks boot copy, programs, flags, halt and mid-run reset.
module tb_basic_cpu_core;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] addr_bus;
    logic       wr_en;
    logic       boot;
    wire  [7:0] data_bus;

    logic [7:0] rom [256];
    logic [7:0] ram [256];
    logic [7:0] img [16];

    int         n_tests = 0;
    int         n_fail  = 0;
    int         bus_err = 0;
    int         st_cnt  = 0;
    logic [7:0] st_addr = 8'h00;
    logic [7:0] st_data = 8'h00;
    int         s0;
    logic       ok;

    cpu_status_if #(.AW(8), .DW(8)) st ();

    basic_cpu_core dut (
        .clk      (clk),
        .rst      (rst),
        .addr_bus (addr_bus),
        .data_bus (data_bus),
        .wr_en    (wr_en),
        .boot     (boot),
        .status   (st)
    );

    always #5 clk = ~clk;

    assign data_bus = boot ? rom[addr_bus] : 8'bz;
    assign data_bus = (!boot && !wr_en) ? ram[addr_bus] : 8'bz;

    always @(posedge clk) begin
        if (wr_en) ram[addr_bus] <= data_bus;
    end

    always @(negedge clk) begin
        if (rst) begin
            if (boot) begin
                if (data_bus !== rom[addr_bus]) bus_err = bus_err + 1;
            end else if (!wr_en) begin
                if (addr_bus < 8'd16 && data_bus !== ram[addr_bus])
                    bus_err = bus_err + 1;
            end else begin
                st_cnt  = st_cnt + 1;
                st_addr = addr_bus;
                st_data = data_bus;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic boot_img();
        for (int i = 0; i < 16; i++) rom[i] = img[i];
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_out", {addr_bus, wr_en, boot}, {8'h00, 1'b0, 1'b1});
        chk("rst_regs", {st.acc, st.pc, st.z, st.c, st.halted}, 0);
        rst = 1'b1;
        #1;
        chk("init_out", {addr_bus, wr_en, boot}, {8'h00, 1'b0, 1'b1});
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("boot_cyc", {addr_bus, wr_en, boot}, {8'(i), 1'b1, 1'b1});
        end
        @(negedge clk);
        chk("fetch0", {addr_bus, wr_en, boot}, {8'h00, 1'b0, 1'b0});
        ok = 1'b1;
        for (int i = 0; i < 16; i++) if (ram[i] !== img[i]) ok = 1'b0;
        chk("ram_copy", ok, 1);
    endtask

    task automatic run_halt(input logic [7:0] exp_pc);
        for (int k = 0; k < 200 && !st.halted; k++) @(negedge clk);
        chk("halt_reached", st.halted, 1);
        chk("halt_bus", {addr_bus, wr_en, boot}, {exp_pc, 1'b0, 1'b0});
        repeat (3) @(negedge clk);
        chk("halt_hold", {addr_bus, st.pc, wr_en}, {exp_pc, exp_pc, 1'b0});
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;

        // Boot copy of 0x80+i.
        for (int i = 0; i < 16; i++) img[i] = 8'h80 + 8'(i);
        boot_img();

        // LDI 5; ADD 14; STA 15; HLT.
        img = '{8'h85, 8'h3E, 8'h2F, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00,
                8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00};
        s0 = st_cnt;
        boot_img();
        run_halt(8'h04);
        chk("alu_acc", {st.acc, st.z, st.c}, {8'h08, 1'b0, 1'b0});
        chk("alu_ram15", ram[15], 8'h08);
        chk("alu_store", {8'(st_cnt - s0), st_addr, st_data},
            {8'd1, 8'h0F, 8'h08});

        // LDI 3; SUB 14 (=3); JZ 6; taken path stores 1.
        img = '{8'h83, 8'h4E, 8'hA6, 8'h2F, 8'hF0, 8'h00, 8'h81, 8'h2F,
                8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00};
        s0 = st_cnt;
        boot_img();
        repeat (4) @(negedge clk);
        chk("sub_eq_flags", {st.acc, st.z, st.c}, {8'h00, 1'b1, 1'b0});
        run_halt(8'h09);
        chk("jz_taken", {st.acc, st.z, st.c}, {8'h01, 1'b0, 1'b0});
        chk("jz_ram15", {ram[15], 8'(st_cnt - s0)}, {8'h01, 8'd1});

        // Same with RAM[14]=4: borrow, branch not taken.
        img[14] = 8'h04;
        s0 = st_cnt;
        boot_img();
        repeat (4) @(negedge clk);
        chk("sub_brw_flags", {st.acc, st.z, st.c}, {8'hFF, 1'b0, 1'b1});
        run_halt(8'h05);
        chk("jz_not_taken", {ram[15], 8'(st_cnt - s0)}, {8'hFF, 8'd1});

        // LDI 1; ADD 14 (0xFF); HLT.
        img = '{8'h81, 8'h3E, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00};
        boot_img();
        run_halt(8'h03);
        chk("add_carry", {st.acc, st.z, st.c}, {8'h00, 1'b1, 1'b1});

        // LDI 1; SHR; HLT.
        img = '{8'h81, 8'hE0, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        boot_img();
        run_halt(8'h03);
        chk("shr_carry", {st.acc, st.z, st.c}, {8'h00, 1'b1, 1'b1});

        // LDA/AND/OR/XOR/NOT/SHL/SHL/JC/JMP/STA 9/HLT.
        img = '{8'h1D, 8'h5C, 8'h6B, 8'h7A, 8'hC0, 8'hD0, 8'hD0, 8'hB9,
                8'hF0, 8'h9E, 8'hFF, 8'h50, 8'h0F, 8'hC3, 8'h29, 8'hF0};
        s0 = st_cnt;
        boot_img();
        run_halt(8'h10);
        chk("logic_acc", {st.acc, st.z, st.c}, {8'h4C, 1'b0, 1'b1});
        chk("logic_store", {ram[9], st_addr, 8'(st_cnt - s0)},
            {8'h4C, 8'h09, 8'd1});

        // Reset during EXEC of HLT, after RAM[15] was written.
        img = '{8'h85, 8'h3E, 8'h2F, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00,
                8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00};
        boot_img();
        repeat (7) @(negedge clk);
        chk("pre_rst_exec", {addr_bus, wr_en, boot, ram[15]},
            {8'h04, 1'b0, 1'b0, 8'h08});
        #2 rst = 1'b0;
        #1;
        chk("async_rst", {addr_bus, wr_en, boot, st.acc},
            {8'h00, 1'b0, 1'b1, 8'h00});
        boot_img();
        chk("reboot_ram15", ram[15], 8'h00);
        run_halt(8'h04);
        chk("rerun", {st.acc, ram[15]}, {8'h08, 8'h08});

        chk("bus_integrity", bus_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
